// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module  : muldiv_pkg
// Brief   : Shared constants, funct codes and FSM encoding for muldiv_unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam int DATA_W = 32;
  localparam int STEPS  = 32;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic logic is_hilo(input logic [5:0] f);
    return is_muldiv(f) || (f == FN_MFHI) || (f == FN_MTHI) ||
           (f == FN_MFLO) || (f == FN_MTLO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_if.sv
// ============================================================================
// Module  : muldiv_if
// Brief   : EX-stage bundle between the pipeline (master) and muldiv_unit (slave).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface muldiv_if #(
  parameter int DATA_W = muldiv_pkg::DATA_W
);
  logic              ex_valid;
  logic [5:0]        function_code;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              ex_flush;
  logic              stall_req;
  logic              busy;
  logic [DATA_W-1:0] mf_data;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  modport master (
    output ex_valid, function_code, rs_data, rt_data, ex_flush,
    input  stall_req, busy, mf_data, hi_out, lo_out
  );

  modport slave (
    input  ex_valid, function_code, rs_data, rt_data, ex_flush,
    output stall_req, busy, mf_data, hi_out, lo_out
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_core.sv
// ============================================================================
// Module  : muldiv_core
// Brief   : 32-step shift-add multiplier / restoring divider on unsigned magnitudes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_core
  import muldiv_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic                fast_i,
  input  logic                is_div_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic                done_o,
  output logic [2*DATA_W-1:0] acc_o
);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                run_q, run_d;
  logic                div_q, div_d;
  logic [DATA_W:0]     w_mul_sum;
  logic [DATA_W:0]     w_div_diff;

  // acc holds {HI, LO}: product accumulates in HI, remainder in HI / quotient in LO
  assign w_mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opnd_q};
  assign w_div_diff = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, opnd_q};

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    div_d  = div_q;
    if (start_i) begin
      div_d = is_div_i;
      if (fast_i) begin
        run_d = 1'b0;
        cnt_d = 5'd0;
        acc_d = is_div_i ? {a_i, {DATA_W{1'b1}}} : '0;
      end else begin
        run_d  = 1'b1;
        cnt_d  = 5'(STEPS - 1);
        acc_d  = {{DATA_W{1'b0}}, (is_div_i ? a_i : b_i)};
        opnd_d = is_div_i ? b_i : a_i;
      end
    end else if (run_q) begin
      if (div_q) begin
        acc_d = w_div_diff[DATA_W] ? {acc_q[2*DATA_W-2:0], 1'b0}
                                   : {w_div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
      end else begin
        acc_d = acc_q[0] ? {w_mul_sum, acc_q[DATA_W-1:1]} : {1'b0, acc_q[2*DATA_W-1:1]};
      end
      if (cnt_q == 5'd0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= 5'd0;
      run_q  <= 1'b0;
      div_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      div_q  <= div_d;
    end
  end

  assign done_o = run_q & (cnt_q == 5'd0);
  assign acc_o  = acc_q;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module  : muldiv_unit
// Brief   : HI/LO register file, mul/div sequencer and stall generation for EX.
//           Optional macro MULDIV_FAST_ZERO_EN: zero-operand ops skip RUN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                  neg_res_q, neg_res_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  div_q, div_d;

  logic                  w_access, w_is_md, w_is_div, w_signed;
  logic                  w_rs_neg, w_rt_neg, w_busy, w_start, w_fast, w_done;
  logic [DATA_W-1:0]     w_a_mag, w_b_mag, w_quo, w_rem;
  logic [2*DATA_W-1:0]   w_acc, w_prod;
  logic [5:0]            w_fc;

  assign w_fc     = bus.function_code;
  assign w_access = bus.ex_valid & ~bus.ex_flush & is_hilo(w_fc);
  assign w_is_md  = is_muldiv(w_fc);
  assign w_is_div = (w_fc == FN_DIV) || (w_fc == FN_DIVU);
  assign w_signed = (w_fc == FN_MULT) || (w_fc == FN_DIV);
  assign w_rs_neg = w_signed & bus.rs_data[DATA_W-1];
  assign w_rt_neg = w_signed & bus.rt_data[DATA_W-1];
  assign w_a_mag  = w_rs_neg ? -bus.rs_data : bus.rs_data;
  assign w_b_mag  = w_rt_neg ? -bus.rt_data : bus.rt_data;
  assign w_busy   = (state_q != ST_IDLE);

`ifdef MULDIV_FAST_ZERO_EN
  assign w_fast = w_is_div ? (bus.rt_data == '0)
                           : ((bus.rs_data == '0) || (bus.rt_data == '0));
`else
  assign w_fast = 1'b0;
`endif

  muldiv_core u_core (
    .clk      (clk),
    .reset    (reset),
    .start_i  (w_start),
    .fast_i   (w_fast),
    .is_div_i (w_is_div),
    .a_i      (w_a_mag),
    .b_i      (w_b_mag),
    .done_o   (w_done),
    .acc_o    (w_acc)
  );

  // Magnitude results corrected back to two's complement in FIX
  assign w_prod = neg_res_q ? -w_acc : w_acc;
  assign w_quo  = neg_res_q ? -w_acc[DATA_W-1:0] : w_acc[DATA_W-1:0];
  assign w_rem  = neg_rem_q ? -w_acc[2*DATA_W-1:DATA_W] : w_acc[2*DATA_W-1:DATA_W];

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div_d     = div_q;
    w_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_access && w_is_md) begin
          w_start   = 1'b1;
          neg_res_d = w_rs_neg ^ w_rt_neg;
          neg_rem_d = w_rs_neg;
          div_d     = w_is_div;
          state_d   = w_fast ? ST_FIX : ST_RUN;
        end else if (w_access && (w_fc == FN_MTHI)) begin
          hi_d = bus.rs_data;
        end else if (w_access && (w_fc == FN_MTLO)) begin
          lo_d = bus.rs_data;
        end
      end
      ST_RUN: begin
        if (w_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        hi_d    = div_q ? w_rem : w_prod[2*DATA_W-1:DATA_W];
        lo_d    = div_q ? w_quo : w_prod[DATA_W-1:0];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div_q     <= div_d;
    end
  end

  assign bus.busy      = w_busy;
  assign bus.stall_req = w_busy & w_access;
  assign bus.mf_data   = (w_fc == FN_MFHI) ? hi_q : lo_q;
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module  : tb_muldiv_unit
// Brief   : Directed self-checking bench for muldiv_unit with a reference model.
//           Honours MULDIV_FAST_ZERO_EN for expected latency.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: architectural HI/LO, cycles left until the pending result lands
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_left;

  function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a, b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f)
      FN_MULT:  return 64'(sa * sb);
      FN_MULTU: return ua * ub;
      FN_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        q = ua / ub;
        r = ua % ub;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, (a[31] ? 32'h00000001 : 32'hFFFFFFFF)};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sq = sa / sb;
        sr = sa % sb;
        q = 64'(sq);
        r = 64'(sr);
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic logic tb_access();
    return bus.ex_valid && !bus.ex_flush && is_hilo(bus.function_code);
  endfunction

  function automatic int latency(input logic [5:0] f, input logic [31:0] a, b);
`ifdef MULDIV_FAST_ZERO_EN
    if ((f == FN_DIV || f == FN_DIVU) && b == 32'h0) return 1;
    if ((f == FN_MULT || f == FN_MULTU) && (a == 32'h0 || b == 32'h0)) return 1;
`endif
    return 33;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi   <= 32'h0;
      m_lo   <= 32'h0;
      m_left <= 0;
      m_pend <= 64'h0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (tb_access()) begin
      if (is_muldiv(bus.function_code)) begin
        m_pend <= ref_result(bus.function_code, bus.rs_data, bus.rt_data);
        m_left <= latency(bus.function_code, bus.rs_data, bus.rt_data);
      end else if (bus.function_code == FN_MTHI) begin
        m_hi <= bus.rs_data;
      end else if (bus.function_code == FN_MTLO) begin
        m_lo <= bus.rs_data;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", {31'h0, bus.busy}, {31'h0, (m_left != 0)});
    chk("stall", {31'h0, bus.stall_req}, {31'h0, (m_left != 0) && tb_access()});
    chk("hi_out", bus.hi_out, m_hi);
    chk("lo_out", bus.lo_out, m_lo);
    if (bus.ex_valid && bus.function_code == FN_MFHI) chk("mf_hi", bus.mf_data, m_hi);
    if (bus.ex_valid && bus.function_code == FN_MFLO) chk("mf_lo", bus.mf_data, m_lo);
  end

  // Present one instruction, holding it while stalled; reports stalls and mf_data
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic fl, output int stalls, output logic [31:0] mf);
    logic st;
    bus.ex_valid      = 1'b1;
    bus.function_code = f;
    bus.rs_data       = a;
    bus.rt_data       = b;
    bus.ex_flush      = fl;
    stalls = 0;
    do begin
      @(negedge clk);
      st = bus.stall_req;
      mf = bus.mf_data;
      @(posedge clk);
      #1;
      if (st) stalls++;
    end while (st && stalls < 200);
    if (stalls >= 200) begin
      total++;
      bad++;
      $display("FAIL issue_timeout actual=%0d required=<200", stalls);
    end
    bus.ex_valid      = 1'b0;
    bus.function_code = 6'h00;
    bus.ex_flush      = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a, b,
                        input logic [31:0] exp_hi, exp_lo);
    int          s;
    logic [31:0] mf;
    issue(f, a, b, 1'b0, s, mf);
    repeat (33) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_hi"}, bus.hi_out, exp_hi);
    chk({name, "_lo"}, bus.lo_out, exp_lo);
  endtask

  initial begin
    int          s;
    logic [31:0] mf;
    bus.ex_valid      = 1'b0;
    bus.function_code = 6'h00;
    bus.rs_data       = 32'h0;
    bus.rt_data       = 32'h0;
    bus.ex_flush      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", bus.hi_out, 32'h0);
    chk("rst_lo", bus.lo_out, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_stall", {31'h0, bus.stall_req}, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("mult", FN_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu", FN_MULTU, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB);

    // DIV -7/2 with MFLO presented at cycle 5 of the operation
    issue(FN_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, s, mf);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    issue(FN_MFLO, 32'h0, 32'h0, 1'b0, s, mf);
    chk("mflo_stalls", 32'(s), 32'd29);
    chk("mflo_data", mf, 32'hFFFFFFFD);
    chk("div_hi", bus.hi_out, 32'hFFFFFFFF);

    run_op("divu0", FN_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
    run_op("divovf", FN_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

    issue(FN_MTHI, 32'h12345678, 32'h0, 1'b0, s, mf);
    issue(FN_MFHI, 32'h0, 32'h0, 1'b0, s, mf);
    chk("mthi_mfhi", mf, 32'h12345678);
    issue(FN_MTLO, 32'h0000DEAD, 32'h0, 1'b1, s, mf);
    issue(FN_MFLO, 32'h0, 32'h0, 1'b0, s, mf);
    chk("mtlo_flushed", mf, 32'h80000000);

    run_op("multu0", FN_MULTU, 32'h0000BEEF, 32'h0, 32'h0, 32'h0);
    run_op("div0neg", FN_DIV, 32'hFFFFFFF7, 32'h0, 32'hFFFFFFF7, 32'h00000001);
    run_op("multu_max", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("div_mix", FN_DIV, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2);

    // Back-to-back: second op stalls until the first one retires
    issue(FN_MULT, 32'd6, 32'd7, 1'b0, s, mf);
    issue(FN_DIVU, 32'd100, 32'd9, 1'b0, s, mf);
    chk("b2b_stalls", 32'(s), 32'd33);
    repeat (33) begin
      @(posedge clk);
      #1;
    end
    chk("b2b_hi", bus.hi_out, 32'd1);
    chk("b2b_lo", bus.lo_out, 32'd11);

    // Reset arriving at cycle 10 of a MULT
    issue(FN_MULT, 32'd3, 32'd5, 1'b0, s, mf);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'h0, bus.busy}, 32'h0);
    chk("midrst_hi", bus.hi_out, 32'h0);
    chk("midrst_lo", bus.lo_out, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_op("post_rst", FN_MULT, 32'd100, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFF38);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide sequencer and HI/LO register file for the EX stage. It decodes the R-type HI/LO function codes passed alongside the ALU control word and runs an iterative 32-step shift-add multiplier or restoring divider. It owns the HI and LO architectural registers and drives a stall request to the hazard unit whenever an instruction touches HI/LO while an operation is in flight.

## Interface
- `DATA_W`, 32: operand and HI/LO width. Only 32 is supported.
- `clk`  in  1  — pipeline clock.
- `reset`  in  1  — asynchronous, active-high.
- `ex_valid`  in  1  — a valid R-type instruction is in EX this cycle.
- `function_code`  in  6  — instruction funct field.
- `rs_data`  in  32  — forwarded rs operand; dividend or multiplicand.
- `rt_data`  in  32  — forwarded rt operand; divisor or multiplier.
- `ex_flush`  in  1  — the EX instruction is being squashed; block it from starting or writing.
- `stall_req`  out  1  — freeze IF/ID/EX this cycle.
- `busy`  out  1  — an operation is in flight.
- `mf_data`  out  32  — MFHI/MFLO result, combinational from the HI/LO registers.
- `hi_out`, `lo_out`  out  32 each  — current HI and LO, for debug.

## Operation
- Decoded funct values:
  - MULT 011000, MULTU 011001: 64-bit product; HI = upper 32 bits, LO = lower 32 bits.
  - DIV 011010, DIVU 011011: LO = quotient, HI = remainder.
  - MFHI 010000, MFLO 010010: read HI or LO.
  - MTHI 010001, MTLO 010011: write HI or LO from `rs_data`.
  - All other funct values are ignored.
- An access is `ex_valid & ~ex_flush & funct ∈ {the 8 codes above}`.
- States and transitions:
  - IDLE → RUN on a MULT/MULTU/DIV/DIVU access. Operands are latched and the 5-bit step counter is set to 31.
  - RUN: one shift-add or shift-subtract step per cycle. RUN → FIX when the counter reaches 0.
  - FIX: sign correction, HI/LO written, then → IDLE.
- Signed ops use the magnitudes of the operands.
  - The product is negated if the operand signs differ.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
- Unsigned ops skip the correction.
- MTHI/MTLO when idle: HI/LO is written at the clock edge. They do not enter RUN.
- `stall_req = busy & access`. Any HI/LO access while busy stalls, including a new mul/div, MF or MT. The stalled instruction re-presents and is accepted the cycle after `busy` falls.
- In-flight operations are never cancelled. `ex_flush` only blocks acceptance of the instruction in EX.
- Boundary cases:
  - DIVU x/0: LO = 0xFFFFFFFF, HI = x.
  - DIV x/0: HI = x; LO = 0xFFFFFFFF if x ≥ 0, else 0x00000001.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wraps, no trap).
- Reset (asynchronous, may arrive mid-RUN):
  - State returns to IDLE.
  - HI = LO = 0, counter = 0.
  - `busy` = 0, `stall_req` = 0.
  - The interrupted operation is lost.

## Timing
- Cycle 0: mul/div accepted. `busy` is 0 in this cycle, so no stall.
- Cycles 1–32: RUN, `busy` = 1.
- Cycle 33: FIX, `busy` = 1.
- Cycle 34: new HI/LO visible on `mf_data`, `busy` = 0.
- Total: 34 cycles from acceptance to readable result. Back-to-back ops have a 34-cycle issue interval.
- MF is zero-latency, with no stall when idle.
- MT result is readable the next cycle.
- `stall_req` is combinational from registered `busy` and the EX inputs. There is no path from `stall_req` back into `busy`.

## Configuration
- `MULDIV_FAST_ZERO_EN` defined: a MULT/MULTU with either operand = 0, or a DIV/DIVU with `rt_data` = 0, goes IDLE → FIX directly.
  - Result is readable at cycle 2.
  - Values are identical to the full-length run.
- Undefined: every operation takes the full 34 cycles.

## Structure
- Shared package `muldiv_pkg`:
  - funct code localparams (8 codes);
  - state encoding (IDLE, RUN, FIX);
  - `DATA_W`, plus step-count constant 32.
- One natural sub-module, `muldiv_core`: the 64-bit iterative shift register, adder/subtractor and step counter. It has `start`, `is_div` and `done` handshakes.
- `muldiv_unit` keeps decode, the FSM, sign correction, HI/LO and stall logic.

## Test plan
- MULT rs = 0xFFFFFFFD (−3), rt = 7 → `busy` cycles 1–33; cycle 34 HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. MULTU with the same operands gives HI = 0x00000006, LO = 0xFFFFFFEB.
- DIV −7/2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7/0 → LO = 0xFFFFFFFF, HI = 7. DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- MFLO issued at cycle 5 of a DIV → `stall_req` = 1 for cycles 5–33; cycle 34 `mf_data` = new LO and no stall.
- MTHI 0x12345678 while idle → next cycle MFHI returns 0x12345678 and `busy` is never asserted. MTLO with `ex_flush` = 1 → LO unchanged.
- Assert `reset` at cycle 10 of a MULT → HI = LO = 0 and `busy` = 0 immediately. A new MULT issued after release completes normally in 34 cycles.
- With `MULDIV_FAST_ZERO_EN`: MULTU x·0 → `busy` only in cycle 1, HI = LO = 0 at cycle 2. Without the macro: same values at cycle 34.
